sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_wl_decoder.sv | 27 ++
 rtl/sram_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM word-line controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_pkg;

    localparam int DEPTH_DEF  = 64;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } sram_state_t;

endpackage

// File: rtl/sram_wl_decoder.sv
// One-hot word-line decoder: drives wl[addr] when en is high, all zero otherwise.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   addr : word address to decode
//   en   : enable; when low every word line is off
//   wl   : DEPTH-bit one-hot (or all-zero) word-line vector
module sram_wl_decoder
    import sram_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [DEPTH-1:0]  wl
);

    always_comb begin
        wl = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wl[i] = en && (addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Sequences single-word reads/writes onto a 32-bit SRAM array (setup, strobe, hold).
// Latency: accept at T, strobe at T+2, response at T+4; out-of-range response at T+1.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
//
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   req_valid/req_ready                 : request handshake
//   req_we, req_addr, req_be, req_wdata : request fields, captured on acceptance
//   rsp_valid/rsp_ready                 : response handshake
//   rsp_rdata, rsp_err                  : read data (0 for writes/errors), out-of-range flag
//   wl, byte_sel, sram_din              : array word lines, byte selects, write data
//   sram_dout                           : read data from the selected word
//   read_pulse, write_pulse             : one-cycle array access strobes
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [DEPTH-1:0]  wl,
    output logic [3:0]        byte_sel,
    output logic [31:0]       sram_din,
    input  logic [31:0]       sram_dout,
    output logic              read_pulse,
    output logic              write_pulse
);

    sram_state_t       state_q, state_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              req_oor;
    logic              array_active;

    // Widen by one bit so DEPTH == 2**ADDR_W is representable in the compare.
    assign req_oor = ({1'b0, req_addr} >= (ADDR_W+1)'(DEPTH));

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    be_d        = req_be;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = '0;
                    if (req_oor) begin
                        // Bad address never touches the array: straight to the response.
                        rsp_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        rsp_err_d = 1'b0;
                        state_d   = SETUP;
                    end
                end
            end
            SETUP: state_d = PULSE;
            PULSE: state_d = HOLD;
            HOLD: begin
                // Array output is settled by the end of HOLD; sample it on the way out.
                if (!we_q) begin
                    rsp_rdata_d = sram_dout;
                end
                state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so req_ready stays low through reset and rises on the first edge after.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array-facing outputs decode straight from the state flop so an async reset
    // (state forced to IDLE) kills the word lines and strobes immediately.
    assign array_active = (state_q == SETUP) || (state_q == PULSE) || (state_q == HOLD);

    sram_wl_decoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wl_decoder (
        .addr (addr_q),
        .en   (array_active),
        .wl   (wl)
    );

    assign byte_sel    = array_active ? (we_q ? be_q : 4'hF) : 4'h0;
    assign sram_din    = array_active ? wdata_q : 32'h0;
    assign write_pulse = (state_q == PULSE) &&  we_q;
    assign read_pulse  = (state_q == PULSE) && !we_q;

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
